reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of architectural registers tracked.
REQ-002 SHALL have parameter CNT_WIDTH, default 2, width of per-register in-flight write counter (max 2^CNT_WIDTH-1 = 3).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 resets).
REQ-005 SHALL have port issueValid  input  1  instruction presented for issue.
REQ-006 SHALL have port issueWb  input  1  presented instruction writes a register.
REQ-007 SHALL have port issueDest  input  4  destination register index.
REQ-008 SHALL have ports src1Valid/src2Valid  input  1 each  source operand used.
REQ-009 SHALL have ports src1/src2  input  4 each  source register indices.
REQ-010 SHALL have port wbValid  input  1  writeback to register file this cycle.
REQ-011 SHALL have port wbDest  input  4  writeback register index.
REQ-012 SHALL have port flush  input  1  pipeline flush; discard all pending writes.
REQ-013 SHALL have port stall  output  1  issue blocked this cycle (combinational).
REQ-014 SHALL have port busyVec  output  REG_COUNT  bit i = counter[i]!=0 (registered state).
REQ-015 SHALL have port underflowErr  output  1  sticky: writeback to register with counter 0.

Function
REQ-016 SHALL keep one CNT_WIDTH-bit counter per register = number of issued, not yet written-back writes.
REQ-017 SHALL assert stall = issueValid && (src1 hazard || src2 hazard || (issueWb && counter[issueDest]==max)); srcN hazard = srcNValid && counter[srcN]!=0.
REQ-018 SHALL accept issue when issueValid && !stall && !flush; accepted issue with issueWb increments counter[issueDest] next edge.
REQ-019 SHALL decrement counter[wbDest] next edge when wbValid && !flush && counter[wbDest]!=0.
REQ-020 SHALL leave counter unchanged when accepted issue and writeback target same register same cycle.
REQ-021 SHALL, on wbValid with counter[wbDest]==0, leave counter at 0 and set underflowErr next edge; held until reset.
REQ-022 SHALL, on flush, clear all counters next edge; flush overrides issue and writeback that cycle; underflowErr unaffected.
REQ-023 SHALL never wrap counters: saturation prevented by stall (REQ-017), underflow by REQ-021.
REQ-024 SHALL ignore issueDest/src/wbDest values when corresponding valid is low; stall=0 when issueValid=0.
REQ-025 SHALL have zero-cycle stall latency and one-cycle state update latency (busyVec reflects accepted issue next cycle).

Reset
REQ-026 SHALL, when rst==0 at a rising edge, clear all counters, busyVec=0, underflowErr=0; reset overrides flush, issue, writeback.
REQ-027 SHALL drive stall from reset state the cycle after reset (only saturation impossible, so stall=0 for any sources).

Configuration
REQ-028 SHALL support macro SCOREBOARD_BYPASS_EN.
REQ-029 With SCOREBOARD_BYPASS_EN defined: register with counter==1 and wbValid && wbDest==srcN this cycle is not a hazard for srcN.
REQ-030 Without SCOREBOARD_BYPASS_EN: hazard is strictly counter!=0; same-cycle writeback does not unblock.

Structure
REQ-031 Shared package arm_sb_pkg SHALL hold REG_COUNT, CNT_WIDTH defaults and the 4-bit register-index type.
REQ-032 Per-register saturating up/down counter SHALL be sub-module sb_counter (inc, dec, clr inputs; count output), instantiated REG_COUNT times.

Verification
REQ-033 Issue dest=R3 (issueWb=1), next cycle issue src1=R3 -> stall=1; wbValid wbDest=R3 -> next cycle stall=0, busyVec[3]=0.
REQ-034 Three accepted writes to R5 without writeback -> counter=3; fourth issue to R5 -> stall=1; one writeback R5 -> fourth accepted next cycle.
REQ-035 Same cycle: accepted issue dest=R7 and writeback R7 with counter=1 -> counter stays 1, busyVec[7]=1.
REQ-036 wbValid wbDest=R9 with counter 0 -> underflowErr=1 next cycle, busyVec[9]=0; stays 1 through flush; cleared by rst=0.
REQ-037 busyVec=16'h00FF, flush=1 with issue dest=R10 -> next cycle busyVec=16'h0000.
REQ-038 Counter[R2]=1, wbValid wbDest=R2, issue src2=R2 -> stall=0 with SCOREBOARD_BYPASS_EN, stall=1 without.

Source files
------------

// File: rtl/arm_sb_pkg.sv
// Shared definitions for the register scoreboard: default sizing and the
// register-index type used by the top level and the bench.
package arm_sb_pkg;

  localparam int REG_COUNT_DEF = 16;
  localparam int CNT_WIDTH_DEF = 2;

  typedef logic [3:0] reg_idx_t;

endpackage : arm_sb_pkg

// File: rtl/sb_counter.sv
// Per-register saturating up/down counter of in-flight writes.
// clr has priority; simultaneous inc and dec cancel out.
module sb_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Both ends are guarded so the count can never wrap, even if a caller misbehaves.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// Register scoreboard tracking in-flight writes per architectural register.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback clear a single pending write hazard.
module reg_scoreboard
  import arm_sb_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issueValid,
  input  logic                 issueWb,
  input  logic [3:0]           issueDest,
  input  logic                 src1Valid,
  input  logic [3:0]           src1,
  input  logic                 src2Valid,
  input  logic [3:0]           src2,
  input  logic                 wbValid,
  input  logic [3:0]           wbDest,
  input  logic                 flush,
  output logic                 stall,
  output logic [REG_COUNT-1:0] busyVec,
  output logic                 underflowErr
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt [REG_COUNT];
  logic                 src1Haz;
  logic                 src2Haz;
  logic                 satHaz;
  logic                 issueAccept;
  logic                 wbEffective;
  logic                 wbUnderflow;
  logic                 underflowErr_q;
  logic                 underflowErr_d;

  // A pending write only blocks a reader unless the bypass lets the last one through this cycle.
  always_comb begin
    src1Haz = src1Valid && (cnt[src1] != '0);
    src2Haz = src2Valid && (cnt[src2] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    if (wbValid && (wbDest == src1) && (cnt[src1] == CNT_WIDTH'(1))) begin
      src1Haz = 1'b0;
    end
    if (wbValid && (wbDest == src2) && (cnt[src2] == CNT_WIDTH'(1))) begin
      src2Haz = 1'b0;
    end
`endif
    satHaz = issueWb && (cnt[issueDest] == CNT_MAX);
  end

  assign stall       = issueValid && (src1Haz || src2Haz || satHaz);
  assign issueAccept = issueValid && !stall && !flush;
  assign wbEffective = wbValid && !flush && (cnt[wbDest] != '0);
  assign wbUnderflow = wbValid && !flush && (cnt[wbDest] == '0);

  for (genvar i = 0; i < REG_COUNT; i++) begin : gCnt
    logic incSel;
    logic decSel;

    assign incSel = issueAccept && issueWb && (issueDest == reg_idx_t'(i));
    assign decSel = wbEffective && (wbDest == reg_idx_t'(i));

    sb_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) uCounter (
      .clk  (clk),
      .rst  (rst),
      .inc  (incSel),
      .dec  (decSel),
      .clr  (flush),
      .count(cnt[i])
    );

    assign busyVec[i] = (cnt[i] != '0);
  end

  // Sticky error survives flush; only reset clears it.
  always_comb begin
    underflowErr_d = underflowErr_q | wbUnderflow;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      underflowErr_q <= 1'b0;
    end else begin
      underflowErr_q <= underflowErr_d;
    end
  end

  assign underflowErr = underflowErr_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver pushes model expectations, a
// negedge monitor pops and compares stall, busyVec and underflowErr.
module tb_reg_scoreboard;

  typedef struct {
    logic        stall;
    logic [15:0] busy;
    logic        uf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        issueValid;
  logic        issueWb;
  logic [3:0]  issueDest;
  logic        src1Valid;
  logic [3:0]  src1;
  logic        src2Valid;
  logic [3:0]  src2;
  logic        wbValid;
  logic [3:0]  wbDest;
  logic        flush;
  logic        stall;
  logic [15:0] busyVec;
  logic        underflowErr;

  exp_t expQ[$];
  exp_t monE;
  int   mCnt[16];
  bit   mUf;
  int   checks;
  int   errors;

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issueValid  (issueValid),
    .issueWb     (issueWb),
    .issueDest   (issueDest),
    .src1Valid   (src1Valid),
    .src1        (src1),
    .src2Valid   (src2Valid),
    .src2        (src2),
    .wbValid     (wbValid),
    .wbDest      (wbDest),
    .flush       (flush),
    .stall       (stall),
    .busyVec     (busyVec),
    .underflowErr(underflowErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit srcHazard(bit v, int s, bit wv, int wd);
    if (!v || mCnt[s] == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (mCnt[s] == 1 && wv && wd == s) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Drive one cycle of inputs, record what the DUT should show, then advance the model.
  task automatic applyStimulus(input bit r, input bit iv, input bit iwb, input int idest,
                               input bit s1v, input int s1, input bit s2v, input int s2,
                               input bit wv, input int wd, input bit fl);
    exp_t e;
    rst        = r;
    issueValid = iv;
    issueWb    = iwb;
    issueDest  = 4'(idest);
    src1Valid  = s1v;
    src1       = 4'(s1);
    src2Valid  = s2v;
    src2       = 4'(s2);
    wbValid    = wv;
    wbDest     = 4'(wd);
    flush      = fl;
    for (int i = 0; i < 16; i++) e.busy[i] = (mCnt[i] != 0);
    e.uf    = mUf;
    e.stall = iv && (srcHazard(s1v, s1, wv, wd) || srcHazard(s2v, s2, wv, wd) ||
                     (iwb && mCnt[idest] == 3));
    expQ.push_back(e);
    if (!r) begin
      for (int i = 0; i < 16; i++) mCnt[i] = 0;
      mUf = 1'b0;
    end else if (fl) begin
      for (int i = 0; i < 16; i++) mCnt[i] = 0;
    end else begin
      if (wv) begin
        if (mCnt[wd] == 0) mUf = 1'b1;
        else mCnt[wd] = mCnt[wd] - 1;
      end
      if (iv && !e.stall && iwb) mCnt[idest] = mCnt[idest] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (stall !== e.stall) begin
      errors++;
      $display("[TB] FAIL stall at %0t: got %b expected %b", $time, stall, e.stall);
    end
    checks++;
    if (busyVec !== e.busy) begin
      errors++;
      $display("[TB] FAIL busyVec at %0t: got %h expected %h", $time, busyVec, e.busy);
    end
    checks++;
    if (underflowErr !== e.uf) begin
      errors++;
      $display("[TB] FAIL underflowErr at %0t: got %b expected %b", $time, underflowErr, e.uf);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  initial begin
    int idest;
    int wd;
    checks = 0;
    errors = 0;
    mUf    = 1'b0;
    for (int i = 0; i < 16; i++) mCnt[i] = 0;
    rst = 1'b0; issueValid = 1'b0; issueWb = 1'b0; issueDest = '0;
    src1Valid = 1'b0; src1 = '0; src2Valid = 1'b0; src2 = '0;
    wbValid = 1'b0; wbDest = '0; flush = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 1, 4, 1, 4, 1, 6, 1, 4, 1);
    idle();

    // Read-after-write hazard on R3 resolved by writeback.
    applyStimulus(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
    applyStimulus(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);

    // Saturation on R5.
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Simultaneous issue and writeback to R7.
    applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    idle();

    // Underflow on R9 is sticky through flush, cleared by reset.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Flush overrides a concurrent issue.
    for (int k = 0; k < 8; k++) applyStimulus(1, 1, 1, k, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Same-cycle writeback vs. reader of R2.
    applyStimulus(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
    idle();

    for (int n = 0; n < 3000; n++) begin
      idest = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      wd    = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                    idest, $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 1), wd, $urandom_range(0, 39) == 0);
    end

    for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_scoreboard
